// File: rtl/seq_alu.sv
// seq_alu: registered CR16 ALU with a valid/ready input handshake, an internal
// status-flag register {L,C,F,Z,N} and an optional iterative shift-add multiplier.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation present on opcode/a/b
//   in_ready   block can accept an operation this cycle
//   opcode     CR16 opcode (8 bits)
//   a, b       Rdest and Rsrc/immediate operands (WIDTH bits)
//   out_valid  one-cycle pulse, result/flags just updated
//   result     registered result, held until the next completion
//   flags      status register {L,C,F,Z,N} = bits [4:0]
//
// Build option: define SEQ_ALU_MUL_EN to include the multiplier. Without it
// MUL/MULI complete in one cycle like an undefined opcode and in_ready is 1.
//
// state | meaning
// IDLE  | ready; non-MUL ops complete at the accepting edge
// MUL   | shift-add multiply in progress, one multiplier bit per cycle

module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int MSB     = WIDTH - 1;
    localparam int FL = 4, FC = 3, FF = 2, FZ = 1, FN = 0;

    localparam logic [7:0] OP_WAIT = 8'h00, OP_AND  = 8'h01, OP_OR   = 8'h02, OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOT  = 8'h04, OP_ADD  = 8'h05, OP_ADDU = 8'h06, OP_ADDC = 8'h07;
    localparam logic [7:0] OP_RSH  = 8'h08, OP_SUB  = 8'h09, OP_SUBC = 8'h0A, OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_LSH  = 8'h0C, OP_MOV  = 8'h0D, OP_ARSH = 8'h0F;
    localparam logic [7:0] OP_ADDI = 8'h50, OP_ADDUI = 8'h60, OP_ADDCI = 8'h70, OP_RSHI = 8'h80;
    localparam logic [7:0] OP_SUBI = 8'h90, OP_SUBCI = 8'hA0, OP_CMPI = 8'hB0, OP_LSHI = 8'hC0;
    localparam logic [7:0] OP_MOVI = 8'hD0, OP_ARSHI = 8'hF0;

    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0]   alu_res;
    logic [4:0]         alu_flags;
    logic [WIDTH:0]     sum_ext, addc_ext, diff_ext, subc_ext;
    logic [SHAMT_W-1:0] shamt;
    logic               set_zn;

    always_comb begin
        alu_res   = '0;
        alu_flags = flags_q;
        set_zn    = 1'b0;
        shamt     = b[SHAMT_W-1:0];
        sum_ext   = {1'b0, a} + {1'b0, b};
        addc_ext  = sum_ext + (WIDTH+1)'(flags_q[FC]);
        diff_ext  = {1'b0, a} - {1'b0, b};
        // bit WIDTH of the extended difference is the borrow-out
        subc_ext  = diff_ext - (WIDTH+1)'(flags_q[FC]);
        case (opcode)
            OP_ADD, OP_ADDI: begin
                alu_res       = sum_ext[MSB:0];
                alu_flags[FF] = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
                alu_flags[FC] = 1'b0;
                alu_flags[FL] = a < b;
                set_zn        = 1'b1;
            end
            OP_SUB, OP_SUBI: begin
                alu_res       = diff_ext[MSB:0];
                alu_flags[FF] = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
                alu_flags[FC] = 1'b0;
                alu_flags[FL] = a < b;
                set_zn        = 1'b1;
            end
            OP_ADDU, OP_ADDUI: begin
                alu_res       = sum_ext[MSB:0];
                alu_flags[FC] = sum_ext[WIDTH];
                alu_flags[FF] = 1'b0;
                alu_flags[FL] = a < b;
                set_zn        = 1'b1;
            end
            OP_ADDC, OP_ADDCI: begin
                alu_res       = addc_ext[MSB:0];
                alu_flags[FC] = addc_ext[WIDTH];
                alu_flags[FF] = 1'b0;
                alu_flags[FL] = a < b;
                set_zn        = 1'b1;
            end
            OP_SUBC, OP_SUBCI: begin
                alu_res       = subc_ext[MSB:0];
                alu_flags[FC] = subc_ext[WIDTH];
                alu_flags[FF] = 1'b0;
                alu_flags[FL] = a < b;
                set_zn        = 1'b1;
            end
            OP_MOV, OP_MOVI: begin
                alu_res       = b;
                alu_flags[FL] = 1'b0;
                alu_flags[FC] = 1'b0;
                alu_flags[FF] = 1'b0;
                set_zn        = 1'b1;
            end
            OP_AND: begin alu_res = a & b; set_zn = 1'b1; end
            OP_OR:  begin alu_res = a | b; set_zn = 1'b1; end
            OP_XOR: begin alu_res = a ^ b; set_zn = 1'b1; end
            OP_NOT: begin alu_res = ~a;    set_zn = 1'b1; end
            OP_LSH, OP_LSHI: begin
                alu_res = a << shamt;
                set_zn  = 1'b1;
            end
            OP_RSH, OP_RSHI: begin
                alu_res = a >> shamt;
                set_zn  = 1'b1;
            end
            OP_ARSH, OP_ARSHI: begin
                alu_res = WIDTH'($signed(a) >>> shamt);
                set_zn  = 1'b1;
            end
            OP_CMP, OP_CMPI: begin
                alu_res       = a;
                alu_flags[FL] = a < b;
                alu_flags[FZ] = a == b;
                alu_flags[FN] = $signed(a) < $signed(b);
            end
            OP_WAIT: alu_res = a;
            default: alu_res = '0;
        endcase
        if (set_zn) begin
            alu_flags[FZ] = (alu_res == '0);
            alu_flags[FN] = alu_res[MSB];
        end
    end

`ifdef SEQ_ALU_MUL_EN
    localparam logic [7:0] OP_MUL = 8'h0E, OP_MULI = 8'hE0;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d, mcand_q, mcand_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    assign in_ready = (state_q == IDLE);
    assign acc_step = acc_q + (mplier_q[cnt_q] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0);

    always_comb begin
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        state_d     = state_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (opcode == OP_MUL || opcode == OP_MULI) begin
                        mplier_d = a;
                        mcand_d  = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
                    result_d    = acc_step[MSB:0];
                    flags_d     = {1'b0, |acc_step[2*WIDTH-1:WIDTH], 1'b0,
                                   acc_step[MSB:0] == '0, acc_step[MSB]};
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            mplier_q    <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
        end
    end
`else
    assign in_ready = 1'b1;

    always_comb begin
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            result_d    = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign result    = result_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH = 16): directed scenarios plus randomized operations
// compared against an arithmetic reference model of the CR16 ALU rules.
module tb_seq_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   opcode = 8'h00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic [4:0]   flags;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] m_flags = 5'b0;

    logic [7:0] ops [27] = '{8'h05, 8'h06, 8'h07, 8'h50, 8'h60, 8'h70, 8'h0D, 8'hD0, 8'h0E,
                             8'hE0, 8'h09, 8'h0A, 8'h90, 8'hA0, 8'h0B, 8'hB0, 8'h01, 8'h02,
                             8'h03, 8'h04, 8'h0C, 8'hC0, 8'h08, 8'h80, 8'h0F, 8'hF0, 8'h00};

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
        .result(result), .flags(flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the CR16 flag rules.
    function automatic void model(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [4:0] fin, output logic [W-1:0] r, output logic [4:0] fo);
        int unsigned ux = x;
        int unsigned uy = y;
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int amt = int'(uy % W);
        int d;
        longint unsigned p;
        bit zn = 1'b0;
        logic fl_l, fl_c, fl_f, fl_z, fl_n;
        {fl_l, fl_c, fl_f, fl_z, fl_n} = fin;
        r = '0;
        case (op)
            8'h05, 8'h50: begin
                r = W'(ux + uy); d = sx + sy;
                fl_f = (d > 32767) || (d < -32768); fl_c = 0; fl_l = ux < uy; zn = 1;
            end
            8'h09, 8'h90: begin
                r = W'(ux - uy); d = sx - sy;
                fl_f = (d > 32767) || (d < -32768); fl_c = 0; fl_l = ux < uy; zn = 1;
            end
            8'h06, 8'h60: begin
                r = W'(ux + uy); fl_c = (ux + uy) > 65535; fl_f = 0; fl_l = ux < uy; zn = 1;
            end
            8'h07, 8'h70: begin
                r = W'(ux + uy + fin[3]); fl_c = (ux + uy + fin[3]) > 65535;
                fl_f = 0; fl_l = ux < uy; zn = 1;
            end
            8'h0A, 8'hA0: begin
                d = int'(ux) - int'(uy) - int'(fin[3]);
                r = W'(d); fl_c = d < 0; fl_f = 0; fl_l = ux < uy; zn = 1;
            end
            8'h0D, 8'hD0: begin r = y; fl_l = 0; fl_c = 0; fl_f = 0; zn = 1; end
`ifdef SEQ_ALU_MUL_EN
            8'h0E, 8'hE0: begin
                p = longint'(ux) * longint'(uy);
                r = W'(p); fl_c = (p >> W) != 0; fl_l = 0; fl_f = 0; zn = 1;
            end
`endif
            8'h01: begin r = x & y; zn = 1; end
            8'h02: begin r = x | y; zn = 1; end
            8'h03: begin r = x ^ y; zn = 1; end
            8'h04: begin r = ~x; zn = 1; end
            8'h0C, 8'hC0: begin r = W'(ux << amt); zn = 1; end
            8'h08, 8'h80: begin r = W'(ux >> amt); zn = 1; end
            8'h0F, 8'hF0: begin r = W'(sx >>> amt); zn = 1; end
            8'h0B, 8'hB0: begin r = x; fl_l = ux < uy; fl_z = ux == uy; fl_n = sx < sy; end
            8'h00: r = x;
            default: r = '0;
        endcase
        if (zn) begin
            fl_z = (r == 0);
            fl_n = r[W-1];
        end
        fo = {fl_l, fl_c, fl_f, fl_z, fl_n};
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the completion edge.
    task automatic do_op(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input string tag);
        logic [W-1:0] er;
        logic [4:0]   ef;
        model(op, x, y, m_flags, er, ef);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; opcode = op; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        if (op == 8'h0E || op == 8'hE0) begin
            int c = 1;
            int busy = 0;
            while (out_valid !== 1'b1 && c < W + 4) begin
                if (in_ready === 1'b0) busy++;
                // junk presented while busy must be ignored
                if (c < W) begin
                    in_valid = 1'b1; opcode = 8'($urandom); a = W'($urandom); b = W'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
                @(posedge clk); #1;
                c++;
            end
            in_valid = 1'b0;
            chk({tag, "_mul_latency"}, c, W + 1);
            chk({tag, "_mul_busy"}, busy, W);
            chk({tag, "_ready_at_done"}, in_ready, 1);
        end
`endif
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_flags"}, flags, ef);
        m_flags = ef;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_out_valid", out_valid, 0);
        end
    endtask

    initial begin
        int ov_seen;
        logic [7:0] op;

        // reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        m_flags = 5'b0;
        idle(1);

        // carry chain
        do_op(8'h06, 16'hFFFF, 16'h0001, "addu");
        chk("addu_c", flags[3], 1);
        chk("addu_z", flags[1], 1);
        do_op(8'h07, 16'h0001, 16'h0000, "addc");
        chk("addc_res", result, 16'h0002);
        chk("addc_c", flags[3], 0);
        chk("addc_z", flags[1], 0);
        idle(1);

        // overflow, then logic op keeps F
        do_op(8'h05, 16'h7FFF, 16'h0001, "add_ovf");
        chk("add_ovf_res", result, 16'h8000);
        chk("add_ovf_fnc", {flags[2], flags[0], flags[3]}, 3'b110);
        do_op(8'h01, 16'h00F0, 16'h000F, "and");
        chk("and_zf", {flags[1], flags[2]}, 2'b11);

        // MUL 0x0100 * 0x0100
        do_op(8'h0E, 16'h0100, 16'h0100, "mul_dir");
        chk("mul_dir_res", result, 16'h0000);
`ifdef SEQ_ALU_MUL_EN
        chk("mul_dir_flags", flags, 5'b01010);
`else
        chk("mul_dir_flags", flags, 5'b00110);
`endif
        idle(1);

        // reset in the middle of a MUL
        in_valid = 1'b1; opcode = 8'h0E; a = 16'h0003; b = 16'h0005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_flags = 5'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        chk("abort_flags", flags, 0);
        ov_seen = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) ov_seen++;
        end
        chk("abort_no_out_valid", ov_seen, 0);
        chk("abort_ready_after", in_ready, 1);

        // CMP then SUBC back-to-back with C=1
        do_op(8'h06, 16'hFFFF, 16'h0001, "set_c");
        do_op(8'h0B, 16'h8000, 16'h0001, "cmp");
        chk("cmp_lzn", {flags[4], flags[1], flags[0]}, 3'b001);
        chk("cmp_c_kept", flags[3], 1);
        do_op(8'h0A, 16'h0005, 16'h0003, "subc");
        chk("subc_res", result, 16'h0001);
        chk("subc_c", flags[3], 0);

        // randomized operations, mostly back-to-back
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) op = 8'($urandom);
            else op = ops[$urandom_range(0, 26)];
            if ($urandom_range(0, 7) == 0) idle(1);
            do_op(op, rnd_opnd(), rnd_opnd(), "rand");
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the lab-1 combinational ALU. Accepts one operation per cycle over a valid/ready handshake, holds the processor status flags (L, C, F, Z, N) in an internal register so ADDC/SUBC consume a real carry/borrow-in, and performs MUL/MULI with an iterative shift-add multiplier. It sits between the register file read ports and the write-back stage of the CR16 datapath.

## Interface
- WIDTH, 16, datapath width in bits; legal values 8..32. SHAMT_W = clog2(WIDTH) is derived, not overridable.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  operation present on opcode/a/b.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- opcode  in  8  CR16 opcode, same encodings as the lab-1 ALU (ADD 05, ADDU 06, ADDC 07, ADDI 50, ADDUI 60, ADDCI 70, MOV 0D, MOVI D0, MUL 0E, MULI E0, SUB 09, SUBC 0A, SUBI 90, SUBCI A0, CMP 0B, CMPI B0, AND 01, OR 02, XOR 03, NOT 04, LSH 0C, LSHI C0, RSH 08, RSHI 80, ARSH 0F, ARSHI F0, WAIT 00).
- a  in  WIDTH  Rdest operand.
- b  in  WIDTH  Rsrc / immediate operand.
- out_valid  out  1  one-cycle pulse: result and flags are updated.
- result  out  WIDTH  registered result; holds until the next completion.
- flags  out  5  status register {L,C,F,Z,N} = bits [4:0].

## Operation
- States: IDLE, MUL. in_ready = (state == IDLE).
- IDLE, accept non-MUL op: result and flags registered at that edge; out_valid = 1 in the following cycle; stay IDLE.
- IDLE, accept MUL/MULI: latch a, b; clear accumulator; go MUL; counter = 0.
- MUL: each cycle add (b << counter) into 2*WIDTH accumulator if a[counter]; counter++. After WIDTH steps, register result/flags, pulse out_valid, return IDLE.
- Flag rules (unlisted flags keep their previous value):
  - ADD/ADDI, SUB/SUBI: signed; F = two's-complement overflow; C = 0; L = a<b unsigned; Z, N from result.
  - ADDU/ADDUI: C = carry-out; F = 0; L, Z, N as above.
  - ADDC/ADDCI: a + b + C_prev; C = carry-out; F = 0; L, Z, N.
  - SUBC/SUBCI: a - b - C_prev; C = borrow-out; F = 0; L, Z, N.
  - MOV/MOVI: result = b; L = C = F = 0; Z, N.
  - MUL/MULI: result = low WIDTH bits (unsigned); C = |high WIDTH bits; L = F = 0; Z, N.
  - AND/OR/XOR/NOT (NOT = ~a), LSH/RSH/ARSH (amount = b[SHAMT_W-1:0]): Z, N only.
  - CMP/CMPI: result = a; L = a<b unsigned; Z = (a==b); N = a<b signed; C, F unchanged.
  - WAIT: result = a; flags unchanged.
  - Undefined opcode: result = 0; flags unchanged; out_valid still pulses.
- No output backpressure; the consumer must take result on the out_valid pulse.

## Timing
- Reset values: result = 0, flags = 0, out_valid = 0, state = IDLE, in_ready = 1 (from the first cycle after reset).
- Non-MUL latency: 1 cycle; throughput 1 op/cycle with in_valid held high.
- MUL latency: out_valid exactly WIDTH+1 cycles after the accept edge; in_ready low for WIDTH cycles. In the out_valid cycle, in_ready = 1 and a new op can be accepted.
- ADDC/SUBC issued back-to-back use the C written by the immediately preceding op (forwarded through the flag register; no bubble).
- rst_n low at any time, including mid-MUL: abort, no out_valid for the aborted op, all outputs to reset values at that edge.
- in_valid while in_ready = 0: ignored; the source must hold.

## Configuration
- SEQ_ALU_MUL_EN defined: iterative multiplier and MUL state present as above.
- Not defined: no MUL state or accumulator. MUL/MULI behave as undefined opcodes (1-cycle, result 0, flags unchanged). in_ready is then constant 1 outside reset.

## Test plan
- Reset: hold rst_n = 0 two cycles -> result 0x0000, flags 5'b00000, out_valid 0, in_ready 1.
- ADDU 0xFFFF + 0x0001 -> 0x0000, C=1, Z=1. Next cycle ADDC 0x0001 + 0x0000 -> 0x0002, C=0, Z=0.
- ADD 0x7FFF + 0x0001 -> 0x8000, F=1, N=1, C=0. Then AND 0x00F0 & 0x000F -> 0x0000, Z=1, F still 1.
- MUL 0x0100 * 0x0100 (macro on) -> in_ready low 16 cycles; out_valid 17 cycles after accept; result 0x0000, C=1, Z=1. Macro off -> result 0x0000 after 1 cycle, flags unchanged.
- rst_n low 5 cycles into a MUL -> no out_valid for it; in_ready = 1 and outputs zero the cycle after release.
- Back-to-back CMP 0x8000 vs 0x0001, then SUBC 0x0005 - 0x0003 with C_prev = 1 -> CMP gives L=0, Z=0, N=1; SUBC gives 0x0001, C=0; out_valid high on two consecutive cycles.
